spi_xfer_ctrl: RTL and testbench

Transfer sequencer for the SPI master. Drives go/enable/last_clk into the SPI clock generator and consumes its pos_edge/neg_edge pulses. Owns the tx/rx shift register, bit counter, slave-select outputs, done pulse and interrupt. Sits between the register interface (start, config, data) and the SPI pads.

---
 rtl/spi_xfer_pkg.sv | 25 ++
 rtl/spi_xfer_shreg.sv | 82 ++++++++
 rtl/spi_xfer_ctrl.sv | 163 ++++++++++++++++
 tb/tb_spi_xfer_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_xfer_pkg.sv
// Shared types and sizing for the SPI transfer sequencer.
// Holds the FSM state enum and the char_len -> bit-length conversion.
package spi_xfer_pkg;

  localparam int MAX_CHAR   = 32;
  localparam int CHAR_LEN_W = 5;
  localparam int CNT_W      = $clog2(MAX_CHAR + 1);
  localparam int IDX_W      = $clog2(MAX_CHAR);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    XFER  = 2'd2,
    FIN   = 2'd3
  } xfer_state_e;

  // A char_len of zero selects a full MAX_CHAR-bit character.
  function automatic logic [CNT_W-1:0] char_len_to_len(input logic [CHAR_LEN_W-1:0] cl);
    if (cl == '0) begin
      return CNT_W'(MAX_CHAR);
    end
    return CNT_W'(cl);
  endfunction

endpackage

// File: rtl/spi_xfer_shreg.sv
// Serial tx/rx shift engine: presents tx bits one at a time and assembles rx bits,
// both in LSB-first or MSB-first order over a character of len bits.
module spi_xfer_shreg
  import spi_xfer_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                load_i,
  input  logic [MAX_CHAR-1:0] data_i,
  input  logic [CNT_W-1:0]    len_i,
  input  logic                lsb_i,
  input  logic                tx_adv_i,
  input  logic                rx_smp_i,
  input  logic                rx_bit_i,
  output logic                ser_o,
  output logic [MAX_CHAR-1:0] rx_next_o
);

  logic [MAX_CHAR-1:0] tx_q;
  logic [MAX_CHAR-1:0] rx_q;
  logic [MAX_CHAR-1:0] rx_d;
  logic [CNT_W-1:0]    len_q;
  logic [CNT_W-1:0]    tx_ptr_q;
  logic [CNT_W-1:0]    rx_ptr_q;
  logic                lsb_q;
  logic                ser_q;
  logic                rx_take;
  logic                tx_take;

  // Position of the k-th serial bit inside the character.
  function automatic logic [IDX_W-1:0] bit_pos(input logic [CNT_W-1:0] k,
                                               input logic [CNT_W-1:0] len,
                                               input logic             lsb_first);
    logic [CNT_W-1:0] p;
    p = lsb_first ? k : (len - k - CNT_W'(1));
    return p[IDX_W-1:0];
  endfunction

  assign rx_take = rx_smp_i && (rx_ptr_q < len_q);
  assign tx_take = tx_adv_i && (tx_ptr_q < len_q);

  always_comb begin
    rx_d = rx_q;
    if (rx_take) begin
      rx_d[bit_pos(rx_ptr_q, len_q, lsb_q)] = rx_bit_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tx_q     <= '0;
      rx_q     <= '0;
      len_q    <= '0;
      tx_ptr_q <= '0;
      rx_ptr_q <= '0;
      lsb_q    <= 1'b0;
      ser_q    <= 1'b0;
    end else if (load_i) begin
      tx_q     <= data_i;
      len_q    <= len_i;
      lsb_q    <= lsb_i;
      ser_q    <= data_i[bit_pos('0, len_i, lsb_i)];
      tx_ptr_q <= CNT_W'(1);
      rx_q     <= '0;
      rx_ptr_q <= '0;
    end else begin
      rx_q <= rx_d;
      if (rx_take) begin
        rx_ptr_q <= rx_ptr_q + CNT_W'(1);
      end
      // Once every bit has been presented the line simply holds its last value.
      if (tx_take) begin
        ser_q    <= tx_q[bit_pos(tx_ptr_q, len_q, lsb_q)];
        tx_ptr_q <= tx_ptr_q + CNT_W'(1);
      end
    end
  end

  assign ser_o     = ser_q;
  assign rx_next_o = rx_d;

endmodule

// File: rtl/spi_xfer_ctrl.sv
// SPI master transfer sequencer: drives the clock generator, shift engine, slave selects,
// done pulse and sticky interrupt. Optional macro SPI_XFER_LOOPBACK_EN adds a loopback input.
module spi_xfer_ctrl
  import spi_xfer_pkg::*;
#(
  parameter int SS_NB = 8
) (
  input  logic                  clk_in,
  input  logic                  rst,
  input  logic                  start,
  input  logic [CHAR_LEN_W-1:0] char_len,
  input  logic [MAX_CHAR-1:0]   tx_data,
  input  logic                  lsb,
  input  logic                  tx_neg,
  input  logic                  rx_neg,
  input  logic                  ass,
  input  logic [SS_NB-1:0]      ss_sel,
  input  logic                  ie,
  input  logic                  int_ack,
  input  logic                  pos_edge,
  input  logic                  neg_edge,
  input  logic                  miso,
`ifdef SPI_XFER_LOOPBACK_EN
  input  logic                  loopback,
`endif
  output logic                  go,
  output logic                  enable,
  output logic                  last_clk,
  output logic                  mosi,
  output logic [SS_NB-1:0]      ss_pad_o,
  output logic                  busy,
  output logic                  done,
  output logic [MAX_CHAR-1:0]   rx_data,
  output logic                  int_o,
  output xfer_state_e           state_dbg
);

  xfer_state_e         state_q;
  logic                go_q;
  logic                enable_q;
  logic                last_clk_q;
  logic                busy_q;
  logic                done_q;
  logic [MAX_CHAR-1:0] rx_data_q;
  logic                int_q;
  logic [CNT_W-1:0]    rx_cnt_q;
  logic                tx_neg_q;
  logic                rx_neg_q;

  logic [CNT_W-1:0]    len_d;
  logic                accept;
  logic                in_xfer;
  logic                tx_edge;
  logic                rx_edge;
  logic                rx_bit;
  logic                ser;
  logic [MAX_CHAR-1:0] rx_next;

  // Request handshake: start is taken only in a cycle where the sequencer is idle
  // (busy low); busy rises the following cycle and any start seen while busy is dropped.
  assign accept  = (state_q == IDLE) && start;
  assign len_d   = char_len_to_len(char_len);
  assign in_xfer = (state_q == XFER);
  assign tx_edge = tx_neg_q ? neg_edge : pos_edge;
  assign rx_edge = rx_neg_q ? neg_edge : pos_edge;

`ifdef SPI_XFER_LOOPBACK_EN
  assign rx_bit = loopback ? ser : miso;
`else
  assign rx_bit = miso;
`endif

  spi_xfer_shreg u_shreg (
    .clk_i     (clk_in),
    .rst_i     (rst),
    .load_i    (accept),
    .data_i    (tx_data),
    .len_i     (len_d),
    .lsb_i     (lsb),
    .tx_adv_i  (in_xfer && tx_edge),
    .rx_smp_i  (in_xfer && rx_edge),
    .rx_bit_i  (rx_bit),
    .ser_o     (ser),
    .rx_next_o (rx_next)
  );

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q    <= IDLE;
      go_q       <= 1'b0;
      enable_q   <= 1'b0;
      last_clk_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rx_data_q  <= '0;
      int_q      <= 1'b0;
      rx_cnt_q   <= '0;
      tx_neg_q   <= 1'b0;
      rx_neg_q   <= 1'b0;
    end else begin
      go_q   <= 1'b0;
      done_q <= 1'b0;
      if (int_ack) begin
        int_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          enable_q   <= 1'b0;
          last_clk_q <= 1'b0;
          if (start) begin
            tx_neg_q <= tx_neg;
            rx_neg_q <= rx_neg;
            rx_cnt_q <= len_d;
            busy_q   <= 1'b1;
            int_q    <= 1'b0;
            go_q     <= 1'b1;
            state_q  <= START;
          end
        end
        START: begin
          enable_q   <= 1'b1;
          last_clk_q <= (rx_cnt_q == CNT_W'(1));
          state_q    <= XFER;
        end
        XFER: begin
          if (rx_edge) begin
            rx_cnt_q <= rx_cnt_q - CNT_W'(1);
            if (rx_cnt_q == CNT_W'(1)) begin
              enable_q   <= 1'b0;
              last_clk_q <= 1'b0;
              done_q     <= 1'b1;
              rx_data_q  <= rx_next;
              state_q    <= FIN;
            end else begin
              last_clk_q <= (rx_cnt_q == CNT_W'(2));
            end
          end
        end
        FIN: begin
          busy_q  <= 1'b0;
          // Setting beats an acknowledge arriving in the same cycle.
          if (ie) begin
            int_q <= 1'b1;
          end
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign go        = go_q;
  assign enable    = enable_q;
  assign last_clk  = last_clk_q;
  assign mosi      = ser;
  assign busy      = busy_q;
  assign done      = done_q;
  assign rx_data   = rx_data_q;
  assign int_o     = int_q;
  assign state_dbg = state_q;
  assign ss_pad_o  = ~(ss_sel & {SS_NB{ass ? busy_q : 1'b1}});

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Bench for spi_xfer_ctrl: the bench plays the clock generator, predicts each received
// word from the bit-ordering rules and checks it in a done-driven scoreboard.
module tb_spi_xfer_ctrl;
  import spi_xfer_pkg::*;

  localparam int W   = MAX_CHAR;
  localparam int NSS = 8;

  // clock / reset
  logic clk_in = 1'b0;
  logic rst;
  always #5 clk_in = ~clk_in;

  logic                  start;
  logic [CHAR_LEN_W-1:0] char_len;
  logic [W-1:0]          tx_data;
  logic                  lsb, tx_neg, rx_neg, ass, ie, int_ack;
  logic [NSS-1:0]        ss_sel;
  logic                  pos_edge, neg_edge;
  logic                  miso, miso_rnd, loop_sel;
  logic                  go, enable, last_clk, mosi, busy, done, int_o;
  logic [NSS-1:0]        ss_pad_o;
  logic [W-1:0]          rx_data;
  xfer_state_e           state_dbg;

  assign miso = loop_sel ? mosi : miso_rnd;

  spi_xfer_ctrl #(.SS_NB(NSS)) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .start     (start),
    .char_len  (char_len),
    .tx_data   (tx_data),
    .lsb       (lsb),
    .tx_neg    (tx_neg),
    .rx_neg    (rx_neg),
    .ass       (ass),
    .ss_sel    (ss_sel),
    .ie        (ie),
    .int_ack   (int_ack),
    .pos_edge  (pos_edge),
    .neg_edge  (neg_edge),
    .miso      (miso),
`ifdef SPI_XFER_LOOPBACK_EN
    .loopback  (1'b0),
`endif
    .go        (go),
    .enable    (enable),
    .last_clk  (last_clk),
    .mosi      (mosi),
    .ss_pad_o  (ss_pad_o),
    .busy      (busy),
    .done      (done),
    .rx_data   (rx_data),
    .int_o     (int_o),
    .state_dbg (state_dbg)
  );

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];
  int done_seen = 0;
  int done_exp  = 0;
  logic done_prev = 1'b0;
  logic exp_int = 1'b0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int ord(input int k, input int len, input logic lsb_first);
    return lsb_first ? k : (len - 1 - k);
  endfunction

  function automatic logic [NSS-1:0] ss_exp(input logic b);
    return ~(ss_sel & {NSS{ass ? b : 1'b1}});
  endfunction

  // scoreboard monitor
  always @(negedge clk_in) begin
    if (done) begin
      done_seen++;
      chk("done_single_cycle", W'(done_prev), '0);
      if (exp_q.size() == 0) chk("unexpected_done", W'(done), '0);
      else chk("rx_data", rx_data, exp_q.pop_front());
    end
    done_prev = done;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // One transfer: accept, play clock generator, check control outputs each cycle.
  task automatic do_xfer(input logic [CHAR_LEN_W-1:0] cl, input logic [W-1:0] data,
                         input logic l, input logic tn, input logic rn, input logic lp,
                         input int div, input logic ie_v, input logic ass_v,
                         input logic [NSS-1:0] ss_v, input int restart_at,
                         input int abort_at, input logic ack_fin);
    int len, k, j, rem, npulse;
    logic is_pos, is_rx, is_tx, smp;
    logic [W-1:0] word;
    len = (cl == '0) ? W : int'(cl);
    start = 1'b1; char_len = cl; tx_data = data; lsb = l; tx_neg = tn; rx_neg = rn;
    loop_sel = lp; ie = ie_v; ass = ass_v; ss_sel = ss_v;
    @(negedge clk_in);
    start = 1'b0;
    exp_int = 1'b0;
    chk("go_after_accept", W'(go), W'(1'b1));
    chk("busy_after_accept", W'(busy), W'(1'b1));
    chk("enable_in_start", W'(enable), '0);
    chk("mosi_first_bit", W'(mosi), W'(data[ord(0, len, l)]));
    chk("int_cleared_by_start", W'(int_o), '0);
    chk("ss_busy", W'(ss_pad_o), W'(ss_exp(1'b1)));
    @(negedge clk_in);
    chk("enable_in_xfer", W'(enable), W'(1'b1));
    chk("go_single", W'(go), '0);
    chk("last_clk_entry", W'(last_clk), W'(len == 1));
    k = 0; j = 0; rem = len; word = '0; npulse = 0;
    while (rem > 0 && npulse < 2 * W + 4) begin
      repeat (div - 1) @(negedge clk_in);
      is_pos = (npulse % 2 == 0);
      is_rx  = rn ? !is_pos : is_pos;
      is_tx  = tn ? !is_pos : is_pos;
      pos_edge = is_pos; neg_edge = !is_pos;
      miso_rnd = 1'($urandom_range(0, 1));
      if (is_rx) begin
        smp = lp ? data[ord(k, len, l)] : miso_rnd;
        word[ord(j, len, l)] = smp;
        j++; rem--;
      end
      if (is_tx && (k + 1 < len)) k++;
      if (restart_at == npulse) start = 1'b1;
      npulse++;
      if (rem == 0 && abort_at < 0) begin
        exp_q.push_back(word);
        done_exp++;
      end
      @(negedge clk_in);
      pos_edge = 1'b0; neg_edge = 1'b0; start = 1'b0;
      if (abort_at >= 0 && j == abort_at) begin
        rst = 1'b1;
        @(negedge clk_in);
        rst = 1'b0;
        exp_int = 1'b0;
        chk("abort_state", W'(state_dbg), W'(IDLE));
        chk("abort_enable", W'(enable), '0);
        chk("abort_busy", W'(busy), '0);
        chk("abort_ss", W'(ss_pad_o), W'({NSS{1'b1}}));
        chk("abort_done", W'(done), '0);
        chk("abort_rx_data", rx_data, '0);
        chk("abort_mosi", W'(mosi), '0);
        return;
      end
      chk("busy_during", W'(busy), W'(1'b1));
      chk("ss_during", W'(ss_pad_o), W'(ss_exp(1'b1)));
      if (rem > 0) begin
        chk("enable_run", W'(enable), W'(1'b1));
        chk("last_clk_run", W'(last_clk), W'(rem == 1));
        chk("mosi_seq", W'(mosi), W'(data[ord(k, len, l)]));
        chk("no_early_done", W'(done), '0);
      end else begin
        chk("done_at_fin", W'(done), W'(1'b1));
        chk("enable_fin", W'(enable), '0);
        chk("state_fin", W'(state_dbg), W'(FIN));
        if (ack_fin) int_ack = 1'b1;
      end
    end
    if (rem > 0) chk("rx_edges_budget", W'(rem), '0);
    @(negedge clk_in);
    int_ack = 1'b0;
    if (ie_v) exp_int = 1'b1;
    chk("busy_after_fin", W'(busy), '0);
    chk("enable_idle", W'(enable), '0);
    chk("int_after_fin", W'(int_o), W'(exp_int));
    chk("ss_idle", W'(ss_pad_o), W'(ss_exp(1'b0)));
    chk("state_idle", W'(state_dbg), W'(IDLE));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; char_len = '0; tx_data = '0; lsb = 1'b0; tx_neg = 1'b0;
    rx_neg = 1'b0; ass = 1'b1; ss_sel = 8'h04; ie = 1'b0; int_ack = 1'b0;
    pos_edge = 1'b0; neg_edge = 1'b0; miso_rnd = 1'b0; loop_sel = 1'b1;
    repeat (3) @(negedge clk_in);
    chk("rst_state", W'(state_dbg), W'(IDLE));
    chk("rst_busy", W'(busy), '0);
    chk("rst_go", W'(go), '0);
    chk("rst_enable", W'(enable), '0);
    chk("rst_last_clk", W'(last_clk), '0);
    chk("rst_mosi", W'(mosi), '0);
    chk("rst_done", W'(done), '0);
    chk("rst_rx_data", rx_data, '0);
    chk("rst_int", W'(int_o), '0);
    chk("rst_ss", W'(ss_pad_o), W'(8'hFF));
    rst = 1'b0;
    @(negedge clk_in);

    // MSB-first byte, external loop, divider 2
    do_xfer(5'd8, 32'h000000A5, 1'b0, 1'b1, 1'b0, 1'b1, 2, 1'b0, 1'b1, 8'h04, -1, -1, 1'b0);
    // full 32-bit LSB-first word
    do_xfer(5'd0, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0, 1'b1, 1, 1'b0, 1'b1, 8'h04, -1, -1, 1'b0);
    // extra start while transferring
    do_xfer(5'd8, 32'h0000003C, 1'b0, 1'b1, 1'b0, 1'b1, 2, 1'b0, 1'b1, 8'h04, 5, -1, 1'b0);
    // reset after 3 of 8 bits, then a clean transfer
    do_xfer(5'd8, 32'h0000005A, 1'b0, 1'b1, 1'b0, 1'b1, 2, 1'b1, 1'b1, 8'h04, -1, 3, 1'b0);
    @(negedge clk_in);
    do_xfer(5'd8, 32'h000000C3, 1'b0, 1'b1, 1'b0, 1'b1, 2, 1'b0, 1'b1, 8'h04, -1, -1, 1'b0);

    // interrupt behaviour
    do_xfer(5'd4, 32'h00000009, 1'b1, 1'b0, 1'b0, 1'b1, 1, 1'b1, 1'b1, 8'h04, -1, -1, 1'b0);
    do_xfer(5'd4, 32'h00000006, 1'b0, 1'b1, 1'b1, 1'b0, 1, 1'b1, 1'b1, 8'h04, -1, -1, 1'b1);
    int_ack = 1'b1;
    @(negedge clk_in);
    int_ack = 1'b0;
    exp_int = 1'b0;
    chk("int_ack_clears", W'(int_o), '0);
    do_xfer(5'd1, 32'h00000001, 1'b0, 1'b0, 1'b1, 1'b1, 3, 1'b1, 1'b1, 8'h04, -1, -1, 1'b0);
    do_xfer(5'd3, 32'h00000005, 1'b1, 1'b0, 1'b1, 1'b1, 1, 1'b0, 1'b1, 8'h04, -1, -1, 1'b0);

    // manual slave select
    ass = 1'b0; ss_sel = 8'h04;
    #1;
    chk("ss_manual_idle", W'(ss_pad_o), W'(8'hFB));
    @(negedge clk_in);
    do_xfer(5'd6, 32'h0000002D, 1'b0, 1'b1, 1'b0, 1'b0, 2, 1'b0, 1'b0, 8'h04, -1, -1, 1'b0);

    // randomized transfers
    for (int i = 0; i < 24; i++) begin
      do_xfer(CHAR_LEN_W'($urandom_range(0, 31)), $urandom, 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              int'($urandom_range(1, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              NSS'($urandom), ($urandom_range(0, 3) == 0) ? 2 : -1, -1,
              1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(negedge clk_in);
    end

    repeat (3) @(negedge clk_in);
    chk("done_count", W'(done_seen), W'(done_exp));
    chk("queue_drained", W'(exp_q.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
